// File: rtl/pong_paddle_ctrl.sv
// N-player paddle controller: 2-flop button sync, per-button debounce, per-frame clamped moves.
// Optional define PADDLE_ACCEL_EN doubles the step after 15 consecutive held ticks.
module pong_paddle_ctrl #(
  parameter int unsigned NUM_PADDLES = 2,
  parameter int unsigned POS_W       = 10,
  parameter int unsigned SCREEN_H    = 480,
  parameter int unsigned PADDLE_H    = 80,
  parameter int unsigned STEP        = 4,
  parameter int unsigned DB_CYCLES   = 250000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         frame_tick,
  input  logic [NUM_PADDLES-1:0]       up_btn,
  input  logic [NUM_PADDLES-1:0]       down_btn,
  output logic [NUM_PADDLES*POS_W-1:0] paddle_y,
  output logic [NUM_PADDLES-1:0]       at_top,
  output logic [NUM_PADDLES-1:0]       at_bottom,
  output logic [2*NUM_PADDLES-1:0]     btn_db
);

  localparam int unsigned NB    = 2 * NUM_PADDLES;
  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam int unsigned YMAX  = SCREEN_H - PADDLE_H;

  localparam logic [POS_W-1:0] Y_MAX   = POS_W'(YMAX);
  localparam logic [POS_W-1:0] Y_RST   = POS_W'(YMAX / 2);
  localparam logic [POS_W:0]   YMAX_W  = (POS_W+1)'(YMAX);
  localparam logic [POS_W:0]   STEP_W  = (POS_W+1)'(STEP);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} move_e;

  logic [NB-1:0]    sync1_q, sync1_d, sync2_q, sync2_d, db_q, db_d;
  logic [CNT_W-1:0] db_cnt_q [NB];
  logic [CNT_W-1:0] db_cnt_d [NB];

  logic [POS_W-1:0] y_q [NUM_PADDLES];
  logic [POS_W-1:0] y_d [NUM_PADDLES];
  logic [NUM_PADDLES-1:0] at_top_q, at_top_d, at_bot_q, at_bot_d;

  move_e          cur_st [NUM_PADDLES];
  logic [POS_W:0] step_w [NUM_PADDLES];
  logic [POS_W:0] sum_w  [NUM_PADDLES];
  logic [POS_W:0] diff_w [NUM_PADDLES];

`ifdef PADDLE_ACCEL_EN
  move_e      st_q   [NUM_PADDLES];
  logic [3:0] hold_q [NUM_PADDLES];
  logic [3:0] hold_d [NUM_PADDLES];
  logic [3:0] eff_hold [NUM_PADDLES];
`endif

  // Synchroniser and debouncer, bits ordered {down, up}
  always_comb begin
    sync1_d = {down_btn, up_btn};
    sync2_d = sync1_q;
    db_d    = db_q;
    for (int unsigned i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Move direction is decoded combinationally from the registered debounced
  // levels, so a tick always acts on the pre-edge btn_db value.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PADDLES; p++) begin
      cur_st[p] = S_IDLE;
      if (db_q[p] && !db_q[NUM_PADDLES+p])      cur_st[p] = S_UP;
      else if (db_q[NUM_PADDLES+p] && !db_q[p]) cur_st[p] = S_DOWN;
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < NUM_PADDLES; p++) begin
`ifdef PADDLE_ACCEL_EN
      eff_hold[p] = (cur_st[p] != st_q[p]) ? 4'd0 : hold_q[p];
      step_w[p]   = (eff_hold[p] == 4'd15) ? (STEP_W << 1) : STEP_W;
      if (cur_st[p] == S_IDLE)
        hold_d[p] = 4'd0;
      else if (frame_tick)
        hold_d[p] = (eff_hold[p] == 4'd15) ? 4'd15 : eff_hold[p] + 4'd1;
      else
        hold_d[p] = eff_hold[p];
`else
      step_w[p] = STEP_W;
`endif
      sum_w[p]  = {1'b0, y_q[p]} + step_w[p];
      diff_w[p] = {1'b0, y_q[p]} - step_w[p];
      y_d[p]    = y_q[p];
      if (frame_tick) begin
        case (cur_st[p])
          S_UP:    y_d[p] = ({1'b0, y_q[p]} >= step_w[p]) ? diff_w[p][POS_W-1:0] : '0;
          S_DOWN:  y_d[p] = (sum_w[p] <= YMAX_W) ? sum_w[p][POS_W-1:0] : Y_MAX;
          default: y_d[p] = y_q[p];
        endcase
      end
      at_top_d[p] = (y_d[p] == '0);
      at_bot_d[p] = (y_d[p] == Y_MAX);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      at_top_q <= '0;
      at_bot_q <= '0;
      for (int unsigned i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      for (int unsigned p = 0; p < NUM_PADDLES; p++) begin
        y_q[p] <= Y_RST;
`ifdef PADDLE_ACCEL_EN
        st_q[p]   <= S_IDLE;
        hold_q[p] <= '0;
`endif
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      db_q     <= db_d;
      at_top_q <= at_top_d;
      at_bot_q <= at_bot_d;
      for (int unsigned i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int unsigned p = 0; p < NUM_PADDLES; p++) begin
        y_q[p] <= y_d[p];
`ifdef PADDLE_ACCEL_EN
        st_q[p]   <= cur_st[p];
        hold_q[p] <= hold_d[p];
`endif
      end
    end
  end

  always_comb begin
    paddle_y = '0;
    for (int unsigned p = 0; p < NUM_PADDLES; p++)
      paddle_y[p*POS_W +: POS_W] = y_q[p];
  end

  assign at_top    = at_top_q;
  assign at_bottom = at_bot_q;
  assign btn_db    = db_q;

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Directed bench for pong_paddle_ctrl with DB_CYCLES=4; reference model of paddle motion.
module tb_pong_paddle_ctrl;

  localparam int NP = 2;
  localparam int PW = 10;
  localparam int YMAX = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          frame_tick = 1'b0;
  logic [NP-1:0] up_btn = '0;
  logic [NP-1:0] down_btn = '0;
  logic [NP*PW-1:0] paddle_y;
  logic [NP-1:0] at_top, at_bottom;
  logic [2*NP-1:0] btn_db;

  int n_tests = 0;
  int n_fail  = 0;

  int m_y    [NP];
  int m_dir  [NP];   // 0 idle, 1 up, 2 down
  int m_hold [NP];

  pong_paddle_ctrl #(.DB_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .up_btn(up_btn), .down_btn(down_btn),
    .paddle_y(paddle_y), .at_top(at_top), .at_bottom(at_bottom), .btn_db(btn_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dut_y(input int p);
    logic [PW-1:0] v;
    v = paddle_y[p*PW +: PW];
    return int'(v);
  endfunction

  task automatic check_all(input string tag);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("%s y%0d", tag, p), dut_y(p), m_y[p]);
      check($sformatf("%s top%0d", tag, p), at_top[p], (m_y[p] == 0));
      check($sformatf("%s bot%0d", tag, p), at_bottom[p], (m_y[p] == YMAX));
    end
  endtask

  task automatic model_tick();
    int step;
    for (int p = 0; p < NP; p++) begin
      step = 4;
`ifdef PADDLE_ACCEL_EN
      if (m_hold[p] == 15) step = 8;
      if (m_dir[p] != 0 && m_hold[p] < 15) m_hold[p]++;
`endif
      if (m_dir[p] == 1) m_y[p] = (m_y[p] >= step) ? m_y[p] - step : 0;
      else if (m_dir[p] == 2) m_y[p] = (m_y[p] + step <= YMAX) ? m_y[p] + step : YMAX;
    end
  endtask

  // frame_tick held high for n consecutive cycles; each cycle is one update
  task automatic ticks(input int n, input string tag);
    @(negedge clk);
    frame_tick = 1'b1;
    repeat (n) begin
      @(negedge clk);
      model_tick();
    end
    frame_tick = 1'b0;
    check_all(tag);
  endtask

  task automatic set_btn(input int p, input logic up, input logic dn);
    up_btn[p]   = up;
    down_btn[p] = dn;
    repeat (8) @(negedge clk);
    m_dir[p]  = (up && !dn) ? 1 : ((dn && !up) ? 2 : 0);
    m_hold[p] = 0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_y[p] = 200; m_dir[p] = 0; m_hold[p] = 0;
    end
  endtask

  initial begin
    model_reset();
    // 1: reset
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst btn_db", btn_db, 0);
    check("rst at_top", at_top, 0);
    check("rst at_bottom", at_bottom, 0);
    check_all("rst");

    // 2: up on player 0, 10 single ticks
    set_btn(0, 1'b1, 1'b0);
    check("up0 btn_db", btn_db, 4'b0001);
    for (int t = 0; t < 10; t++) ticks(1, "up0");
    check("up0 y0=160", dut_y(0), 160);
    check("up0 y1=200", dut_y(1), 200);
    set_btn(0, 1'b0, 1'b0);
    check("rel0 btn_db", btn_db, 0);

    // 3: down on player 1 until clamp at YMAX
    set_btn(1, 1'b0, 1'b1);
    check("dn1 btn_db", btn_db, 4'b1000);
    for (int t = 0; t < 60; t++) ticks(1, "dn1");
    check("dn1 y1=400", dut_y(1), 400);
    check("dn1 at_bottom", at_bottom, 2'b10);
    set_btn(1, 1'b0, 1'b0);

    // 4: 3-cycle glitch is filtered
    up_btn[0] = 1'b1;
    repeat (3) @(negedge clk);
    up_btn[0] = 1'b0;
    for (int c = 0; c < 8; c++) begin
      check("glitch btn_db", btn_db, 0);
      @(negedge clk);
    end
    ticks(1, "glitch");

    // 5: both buttons hold, then release down moves up; consecutive ticks
    set_btn(0, 1'b1, 1'b1);
    check("both btn_db", btn_db, 4'b0101);
    ticks(5, "both");
    check("both y0 held", dut_y(0), 160);
    set_btn(0, 1'b1, 1'b0);
    ticks(3, "after both");
    check("after both y0", dut_y(0), 148);

    // top clamp on player 0
    for (int t = 0; t < 45; t++) ticks(1, "top0");
    check("top0 y0", dut_y(0), 0);
    check("top0 at_top", at_top, 2'b01);
    set_btn(0, 1'b0, 1'b0);

    // reset mid-debounce and mid-position
    set_btn(1, 1'b1, 1'b0);
    ticks(2, "pre-rst");
    up_btn[0] = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst y0", dut_y(0), 200);
    check("async rst y1", dut_y(1), 200);
    check("async rst btn_db", btn_db, 0);
    up_btn = '0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    check("post rst btn_db", btn_db, 0);
    ticks(1, "post rst");

`ifdef PADDLE_ACCEL_EN
    // 6: acceleration after 15 held ticks
    set_btn(0, 1'b1, 1'b0);
    for (int t = 0; t < 15; t++) ticks(1, "accel");
    check("accel y0=140", dut_y(0), 140);
    ticks(1, "accel16");
    check("accel y0=132", dut_y(0), 132);
    for (int t = 0; t < 20; t++) ticks(1, "accel clamp");
    check("accel y0=0", dut_y(0), 0);
    set_btn(0, 1'b0, 1'b0);
    set_btn(0, 1'b0, 1'b1);
    ticks(1, "accel restart");
    check("accel restart y0=4", dut_y(0), 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
